b_resp_router: RTL and testbench

Parametrised write-response (B) channel router for the AXI interconnect. It arbitrates round-robin among `NUM_DN` downstream B channels (M-side, facing slaves) and routes each response by BID to one of `NUM_UP` upstream B channels (S-side, facing masters). When the AW path splits one master transaction into several downstream bursts, the router absorbs the intermediate sub-responses and returns a single merged, worst-case response. It replaces the fixed 2x2 B-channel controller path.

---
 rtl/b_resp_router.sv | 212 +++++++++++++++++++++
 tb/tb_b_resp_router.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/b_resp_router.sv
// AXI write-response router: round-robin over downstream B channels, BID-routed to
// upstream B channels, with merging of split-burst sub-responses into one worst case.
module b_resp_router #(
  parameter int NUM_UP = 2,
  parameter int NUM_DN = 2,
  parameter int ID_W   = $clog2(NUM_UP),
  parameter int CNT_W  = 8
) (
  input  logic                   ACLK,
  input  logic                   ARESETN,
  input  logic [NUM_DN*ID_W-1:0] M_AXI_bid,
  input  logic [NUM_DN*2-1:0]    M_AXI_bresp,
  input  logic [NUM_DN-1:0]      M_AXI_bvalid,
  output logic [NUM_DN-1:0]      M_AXI_bready,
  output logic [NUM_UP*2-1:0]    S_AXI_bresp,
  output logic [NUM_UP-1:0]      S_AXI_bvalid,
  input  logic [NUM_UP-1:0]      S_AXI_bready,
  input  logic                   split_load,
  input  logic [ID_W-1:0]        split_id,
  input  logic [CNT_W-1:0]       split_count,
  output logic                   busy,
  output logic                   bid_err,
  output logic                   split_overrun
);

  localparam int DN_W = $clog2(NUM_DN);

  typedef enum logic {IDLE, SEND} state_e;

  state_e           state_q, state_d;
  logic [DN_W-1:0]  last_g_q, last_g_d;
  logic [CNT_W-1:0] cnt_q [NUM_UP];
  logic [CNT_W-1:0] cnt_d [NUM_UP];
  logic [1:0]       acc_q [NUM_UP];
  logic [1:0]       acc_d [NUM_UP];
  logic [ID_W-1:0]  out_id_q, out_id_d;
  logic [1:0]       out_resp_q, out_resp_d;
  logic             busy_q, busy_d;
  logic             bid_err_q, bid_err_d;
  logic             ovr_q, ovr_d;

  logic             grant_vld;
  logic [DN_W-1:0]  grant;
  int               rr_idx;
  logic [ID_W-1:0]  cap_id;
  logic [1:0]       cap_resp;
  logic             id_ok;
  logic [CNT_W-1:0] cur_cnt;
  logic [1:0]       cur_acc;
  logic             load_hit;
  logic             up_ready;

  // Severity order EXOKAY < OKAY < SLVERR < DECERR; EXOKAY is the neutral element.
  function automatic logic [1:0] resp_rank(input logic [1:0] r);
    case (r)
      2'b01:   return 2'd0;
      2'b00:   return 2'd1;
      default: return r;
    endcase
  endfunction

  function automatic logic [1:0] resp_merge(input logic [1:0] a, input logic [1:0] b);
    return (resp_rank(b) > resp_rank(a)) ? b : a;
  endfunction

  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    rr_idx    = 0;
    for (int k = 1; k <= NUM_DN; k++) begin
      rr_idx = (int'(last_g_q) + k) % NUM_DN;
      if (!grant_vld && M_AXI_bvalid[rr_idx[DN_W-1:0]]) begin
        grant_vld = 1'b1;
        grant     = rr_idx[DN_W-1:0];
      end
    end
  end

  // Out-of-range BIDs simply match no upstream slot, which is what flags them.
  always_comb begin
    cap_id   = '0;
    cap_resp = '0;
    for (int k = 0; k < NUM_DN; k++) begin
      if (grant == DN_W'(k)) begin
        cap_id   = M_AXI_bid[k*ID_W +: ID_W];
        cap_resp = M_AXI_bresp[2*k +: 2];
      end
    end
    id_ok   = 1'b0;
    cur_cnt = '0;
    cur_acc = 2'b01;
    for (int u = 0; u < NUM_UP; u++) begin
      if (cap_id == ID_W'(u)) begin
        id_ok   = 1'b1;
        cur_cnt = cnt_q[u];
        cur_acc = acc_q[u];
      end
    end
    up_ready = 1'b0;
    for (int u = 0; u < NUM_UP; u++) begin
      if (out_id_q == ID_W'(u) && S_AXI_bready[u]) up_ready = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_g_d     = last_g_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    out_id_d     = out_id_q;
    out_resp_d   = out_resp_q;
    bid_err_d    = 1'b0;
    ovr_d        = 1'b0;
    load_hit     = 1'b0;
    busy_d       = 1'b0;
    M_AXI_bready = '0;

    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          M_AXI_bready[grant] = ARESETN;
          last_g_d            = grant;
          if (!id_ok) begin
            bid_err_d = 1'b1;
          end else if (cur_cnt > CNT_W'(1)) begin
            for (int u = 0; u < NUM_UP; u++) begin
              if (cap_id == ID_W'(u)) begin
                acc_d[u] = resp_merge(acc_q[u], cap_resp);
                cnt_d[u] = cnt_q[u] - CNT_W'(1);
              end
            end
          end else begin
            out_id_d   = cap_id;
            out_resp_d = resp_merge(cur_acc, cap_resp);
            state_d    = SEND;
            for (int u = 0; u < NUM_UP; u++) begin
              if (cap_id == ID_W'(u)) begin
                cnt_d[u] = '0;
                acc_d[u] = 2'b01;
              end
            end
          end
        end
      end
      SEND: begin
        if (up_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // The load is judged on the pre-capture count but overrides the capture's clear.
    if (split_load) begin
      for (int u = 0; u < NUM_UP; u++) begin
        if (split_id == ID_W'(u)) begin
          load_hit = 1'b1;
          if (cnt_q[u] == '0) cnt_d[u] = split_count;
          else                ovr_d    = 1'b1;
        end
      end
      if (!load_hit) ovr_d = 1'b1;
    end

    busy_d = (state_d == SEND);
    for (int u = 0; u < NUM_UP; u++) begin
      if (cnt_d[u] > CNT_W'(1)) busy_d = 1'b1;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q    <= IDLE;
      last_g_q   <= DN_W'(NUM_DN - 1);
      for (int u = 0; u < NUM_UP; u++) begin
        cnt_q[u] <= '0;
        acc_q[u] <= 2'b01;
      end
      out_id_q   <= '0;
      out_resp_q <= 2'b00;
      busy_q     <= 1'b0;
      bid_err_q  <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_g_q   <= last_g_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      out_id_q   <= out_id_d;
      out_resp_q <= out_resp_d;
      busy_q     <= busy_d;
      bid_err_q  <= bid_err_d;
      ovr_q      <= ovr_d;
    end
  end

  always_comb begin
    S_AXI_bvalid = '0;
    S_AXI_bresp  = '0;
    if (state_q == SEND) begin
      for (int u = 0; u < NUM_UP; u++) begin
        if (out_id_q == ID_W'(u)) begin
          S_AXI_bvalid[u]      = 1'b1;
          S_AXI_bresp[2*u +: 2] = out_resp_q;
        end
      end
    end
  end

  assign busy          = busy_q;
  assign bid_err       = bid_err_q;
  assign split_overrun = ovr_q;

endmodule

// File: tb/tb_b_resp_router.sv
// Bench for b_resp_router: directed scenarios plus a randomized run against a
// rank-based reference model of the routing/merging rules.
module tb_b_resp_router;
  localparam int NU = 3;
  localparam int ND = 3;
  localparam int IW = 2;
  localparam int CW = 8;

  logic           ACLK = 1'b0;
  logic           ARESETN = 1'b0;
  logic [ND*IW-1:0] m_bid;
  logic [ND*2-1:0]  m_bresp;
  logic [ND-1:0]    m_bvalid;
  logic [ND-1:0]    m_bready;
  logic [NU*2-1:0]  s_bresp;
  logic [NU-1:0]    s_bvalid;
  logic [NU-1:0]    s_bready;
  logic             split_load;
  logic [IW-1:0]    split_id;
  logic [CW-1:0]    split_count;
  logic             busy, bid_err, split_overrun;

  int vectors = 0;
  int errors  = 0;

  b_resp_router #(.NUM_UP(NU), .NUM_DN(ND), .ID_W(IW), .CNT_W(CW)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .M_AXI_bid(m_bid), .M_AXI_bresp(m_bresp), .M_AXI_bvalid(m_bvalid), .M_AXI_bready(m_bready),
    .S_AXI_bresp(s_bresp), .S_AXI_bvalid(s_bvalid), .S_AXI_bready(s_bready),
    .split_load(split_load), .split_id(split_id), .split_count(split_count),
    .busy(busy), .bid_err(bid_err), .split_overrun(split_overrun)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, vectors=%0d", vectors);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic clear_inputs();
    m_bid = '0; m_bresp = '0; m_bvalid = '0; s_bready = '0;
    split_load = 1'b0; split_id = '0; split_count = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    ARESETN = 1'b0;
    repeat (2) @(posedge ACLK);
    #1 ARESETN = 1'b1;
  endtask

  task automatic set_dn(input int k, input int id, input logic [1:0] r);
    m_bvalid[k] = 1'b1;
    m_bid[k*IW +: IW] = IW'(id);
    m_bresp[k*2 +: 2] = r;
  endtask

  function automatic int rank_of(input logic [1:0] r);
    case (r)
      2'b01:   return 0;
      2'b00:   return 1;
      2'b10:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic test_reset();
    clear_inputs();
    m_bvalid = 3'b111;
    ARESETN = 1'b0;
    repeat (2) @(posedge ACLK);
    #1;
    vectors++; if (m_bready !== 3'b000) begin errors++; $display("FAIL reset_bready: got %b want 000", m_bready); end
    vectors++; if (s_bvalid !== 3'b000) begin errors++; $display("FAIL reset_bvalid: got %b want 000", s_bvalid); end
    vectors++; if (s_bresp !== 6'b0) begin errors++; $display("FAIL reset_bresp: got %b want 000000", s_bresp); end
    vectors++; if ({busy, bid_err, split_overrun} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {busy, bid_err, split_overrun}); end
    clear_inputs();
    #1 ARESETN = 1'b1;
  endtask

  task automatic test_unsplit();
    apply_reset();
    set_dn(0, 1, 2'b00);
    #1;
    vectors++; if (m_bready !== 3'b001) begin errors++; $display("FAIL unsplit_bready: got %b want 001", m_bready); end
    tick();
    m_bvalid = '0;
    vectors++; if (s_bvalid !== 3'b010) begin errors++; $display("FAIL unsplit_valid: got %b want 010", s_bvalid); end
    vectors++; if (s_bresp !== 6'b0) begin errors++; $display("FAIL unsplit_resp: got %b want 000000", s_bresp); end
    vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL unsplit_busy: got %b want 1", busy); end
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++; if (s_bvalid !== 3'b010) begin errors++; $display("FAIL unsplit_hold%0d: got %b want 010", i, s_bvalid); end
    end
    s_bready = 3'b010;
    tick();
    s_bready = '0;
    vectors++; if (s_bvalid !== 3'b000) begin errors++; $display("FAIL unsplit_drop: got %b want 000", s_bvalid); end
  endtask

  task automatic test_split_merge();
    apply_reset();
    split_load = 1'b1; split_id = 2'd0; split_count = 8'd3;
    tick();
    split_load = 1'b0;
    vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL split_busy: got %b want 1", busy); end
    set_dn(0, 0, 2'b01);
    #1;
    vectors++; if (m_bready !== 3'b001) begin errors++; $display("FAIL split_bready: got %b want 001", m_bready); end
    tick();
    m_bvalid = '0;
    vectors++; if (s_bvalid !== 3'b000) begin errors++; $display("FAIL split_absorb1: got %b want 000", s_bvalid); end
    set_dn(1, 0, 2'b10);
    tick();
    m_bvalid = '0;
    vectors++; if (s_bvalid !== 3'b000) begin errors++; $display("FAIL split_absorb2: got %b want 000", s_bvalid); end
    set_dn(2, 0, 2'b00);
    tick();
    m_bvalid = '0;
    vectors++; if (s_bvalid !== 3'b001) begin errors++; $display("FAIL split_fwd_valid: got %b want 001", s_bvalid); end
    vectors++; if (s_bresp !== 6'b000010) begin errors++; $display("FAIL split_fwd_resp: got %b want 000010", s_bresp); end
    s_bready = 3'b001;
    tick();
    s_bready = '0;
    vectors++; if ({s_bvalid, busy} !== 4'b0000) begin errors++; $display("FAIL split_done: got %b want 0000", {s_bvalid, busy}); end
    split_load = 1'b1; split_id = 2'd0; split_count = 8'd2;
    tick();
    split_load = 1'b0;
    vectors++; if (split_overrun !== 1'b0) begin errors++; $display("FAIL split_cnt_cleared: got %b want 0", split_overrun); end
  endtask

  task automatic test_round_robin();
    apply_reset();
    set_dn(0, 0, 2'b00);
    set_dn(1, 1, 2'b10);
    s_bready = '1;
    #1;
    for (int i = 0; i < 2; i++) begin
      vectors++; if (m_bready !== 3'b001) begin errors++; $display("FAIL rr_dn0_%0d: got %b want 001", i, m_bready); end
      tick();
      vectors++; if ({s_bvalid, m_bready} !== 6'b001000) begin errors++; $display("FAIL rr_send0_%0d: got %b want 001000", i, {s_bvalid, m_bready}); end
      tick();
      vectors++; if (m_bready !== 3'b010) begin errors++; $display("FAIL rr_dn1_%0d: got %b want 010", i, m_bready); end
      tick();
      vectors++; if ({s_bvalid, s_bresp} !== 9'b010_001000) begin errors++; $display("FAIL rr_send1_%0d: got %b want 010001000", i, {s_bvalid, s_bresp}); end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_bad_bid();
    apply_reset();
    set_dn(2, 3, 2'b10);
    #1;
    vectors++; if (m_bready !== 3'b100) begin errors++; $display("FAIL badbid_bready: got %b want 100", m_bready); end
    tick();
    m_bvalid = '0;
    vectors++; if ({bid_err, s_bvalid} !== 4'b1000) begin errors++; $display("FAIL badbid_pulse: got %b want 1000", {bid_err, s_bvalid}); end
    tick();
    vectors++; if ({bid_err, s_bvalid} !== 4'b0000) begin errors++; $display("FAIL badbid_after: got %b want 0000", {bid_err, s_bvalid}); end
  endtask

  task automatic test_overrun();
    apply_reset();
    split_load = 1'b1; split_id = 2'd1; split_count = 8'd2;
    tick();
    split_count = 8'd5;
    tick();
    split_load = 1'b0;
    vectors++; if ({split_overrun, busy} !== 2'b11) begin errors++; $display("FAIL ovr_pulse: got %b want 11", {split_overrun, busy}); end
    tick();
    vectors++; if (split_overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b want 0", split_overrun); end
    set_dn(0, 1, 2'b10);
    tick();
    m_bvalid = '0;
    vectors++; if (s_bvalid !== 3'b000) begin errors++; $display("FAIL ovr_absorb: got %b want 000", s_bvalid); end
    set_dn(1, 1, 2'b01);
    tick();
    m_bvalid = '0;
    vectors++; if ({s_bvalid, s_bresp} !== 9'b010_001000) begin errors++; $display("FAIL ovr_count_kept: got %b want 010001000", {s_bvalid, s_bresp}); end
    s_bready = 3'b010;
    tick();
    s_bready = '0;
  endtask

  task automatic test_collision();
    apply_reset();
    set_dn(0, 2, 2'b11);
    split_load = 1'b1; split_id = 2'd2; split_count = 8'd2;
    tick();
    clear_inputs();
    vectors++; if ({s_bvalid, s_bresp, split_overrun} !== 10'b100_110000_0) begin errors++; $display("FAIL coll_fwd: got %b want 1001100000", {s_bvalid, s_bresp, split_overrun}); end
    s_bready = 3'b100;
    tick();
    s_bready = '0;
    vectors++; if ({s_bvalid, busy} !== 4'b0001) begin errors++; $display("FAIL coll_loaded: got %b want 0001", {s_bvalid, busy}); end
    set_dn(1, 2, 2'b00);
    tick();
    m_bvalid = '0;
    vectors++; if ({s_bvalid, busy} !== 4'b0000) begin errors++; $display("FAIL coll_absorb: got %b want 0000", {s_bvalid, busy}); end
    set_dn(2, 2, 2'b01);
    tick();
    m_bvalid = '0;
    vectors++; if ({s_bvalid, s_bresp} !== 9'b100_000000) begin errors++; $display("FAIL coll_final: got %b want 100000000", {s_bvalid, s_bresp}); end
  endtask

  task automatic test_reset_in_send();
    apply_reset();
    set_dn(1, 1, 2'b10);
    tick();
    m_bvalid = '0;
    vectors++; if (s_bvalid !== 3'b010) begin errors++; $display("FAIL rst_send_valid: got %b want 010", s_bvalid); end
    #2 ARESETN = 1'b0;
    #1;
    vectors++; if ({s_bvalid, s_bresp, busy} !== 10'b0) begin errors++; $display("FAIL rst_async_drop: got %b want 0000000000", {s_bvalid, s_bresp, busy}); end
    @(posedge ACLK);
    #1 ARESETN = 1'b1;
    set_dn(0, 0, 2'b00);
    set_dn(2, 1, 2'b00);
    #1;
    vectors++; if (m_bready !== 3'b001) begin errors++; $display("FAIL rst_port0_first: got %b want 001", m_bready); end
    tick();
    clear_inputs();
    s_bready = '1;
    tick();
    clear_inputs();
  endtask

  task automatic test_random();
    int mcnt [NU];
    int macc [NU];
    int oc [NU];
    bit msend;
    int mout_id, mout_rank, mlast;
    bit pv [ND];
    int pid [ND];
    logic [1:0] presp [ND];
    bit e_berr, e_ovr, e_busy;
    int g, id, j, sid;
    logic [NU-1:0]   ev;
    logic [2*NU-1:0] er;
    logic [ND-1:0]   eb;
    logic [1:0] rank2code [4];
    rank2code = '{2'b01, 2'b00, 2'b10, 2'b11};
    apply_reset();
    msend = 1'b0; mout_id = 0; mout_rank = 0; mlast = ND - 1;
    e_berr = 1'b0; e_ovr = 1'b0; e_busy = 1'b0;
    for (int u = 0; u < NU; u++) begin mcnt[u] = 0; macc[u] = 0; end
    for (int k = 0; k < ND; k++) begin pv[k] = 1'b0; pid[k] = 0; presp[k] = 2'b00; end
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < ND; k++) begin
        if (!pv[k] && $urandom_range(0, 99) < 45) begin
          pv[k] = 1'b1;
          pid[k] = (($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2)));
          presp[k] = 2'($urandom_range(0, 3));
        end
        m_bvalid[k] = pv[k];
        m_bid[k*IW +: IW] = IW'(pid[k]);
        m_bresp[k*2 +: 2] = presp[k];
      end
      s_bready    = NU'($urandom_range(0, 7));
      split_load  = ($urandom_range(0, 99) < 12);
      split_id    = IW'($urandom_range(0, 3));
      split_count = CW'($urandom_range(0, 4));

      g = -1;
      if (!msend) begin
        for (int k = 1; k <= ND; k++) begin
          j = (mlast + k) % ND;
          if (g < 0 && pv[j]) g = j;
        end
      end
      ev = '0; er = '0; eb = '0;
      if (msend) begin
        ev[mout_id] = 1'b1;
        er[2*mout_id +: 2] = rank2code[mout_rank];
      end
      if (g >= 0) eb[g] = 1'b1;

      #1;
      vectors++; if (m_bready !== eb) begin errors++; $display("FAIL rnd_bready c=%0d: got %b want %b", c, m_bready, eb); end
      vectors++; if (s_bvalid !== ev) begin errors++; $display("FAIL rnd_bvalid c=%0d: got %b want %b", c, s_bvalid, ev); end
      vectors++; if (s_bresp !== er) begin errors++; $display("FAIL rnd_bresp c=%0d: got %b want %b", c, s_bresp, er); end
      vectors++; if (busy !== e_busy) begin errors++; $display("FAIL rnd_busy c=%0d: got %b want %b", c, busy, e_busy); end
      vectors++; if (bid_err !== e_berr) begin errors++; $display("FAIL rnd_bid_err c=%0d: got %b want %b", c, bid_err, e_berr); end
      vectors++; if (split_overrun !== e_ovr) begin errors++; $display("FAIL rnd_overrun c=%0d: got %b want %b", c, split_overrun, e_ovr); end

      for (int u = 0; u < NU; u++) oc[u] = mcnt[u];
      e_berr = 1'b0;
      e_ovr  = 1'b0;
      if (msend) begin
        if (s_bready[mout_id]) msend = 1'b0;
      end else if (g >= 0) begin
        mlast = g;
        pv[g] = 1'b0;
        id = pid[g];
        if (id >= NU) begin
          e_berr = 1'b1;
        end else if (oc[id] > 1) begin
          if (rank_of(presp[g]) > macc[id]) macc[id] = rank_of(presp[g]);
          mcnt[id] = mcnt[id] - 1;
        end else begin
          mout_id = id;
          mout_rank = (rank_of(presp[g]) > macc[id]) ? rank_of(presp[g]) : macc[id];
          msend = 1'b1;
          mcnt[id] = 0;
          macc[id] = 0;
        end
      end
      if (split_load) begin
        sid = int'(split_id);
        if (sid < NU && oc[sid] == 0) mcnt[sid] = int'(split_count);
        else e_ovr = 1'b1;
      end
      e_busy = msend;
      for (int u = 0; u < NU; u++) if (mcnt[u] > 1) e_busy = 1'b1;
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_unsplit();
    test_split_merge();
    test_round_robin();
    test_bad_bid();
    test_overrun();
    test_collision();
    test_reset_in_send();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
